// File: rtl/freq_sweep_opt_if.sv
// Sweep optimiser bus: sequencer request, ADC sample stream and the sweep results.
// Ports: enable, adc[11:0], adc_valid (sequencer/ADC -> optimiser);
//        new_freq[19:0], best_freq[19:0], best_mag[11:0], busy, done (optimiser -> PWM/sequencer).
interface freq_sweep_opt_if;
  logic        enable;
  logic [11:0] adc;
  logic        adc_valid;
  logic [19:0] new_freq;
  logic [19:0] best_freq;
  logic [11:0] best_mag;
  logic        busy;
  logic        done;

  // Sequencer / ADC side
  modport master (
    output enable, adc, adc_valid,
    input  new_freq, best_freq, best_mag, busy, done
  );

  // Optimiser side
  modport slave (
    input  enable, adc, adc_valid,
    output new_freq, best_freq, best_mag, busy, done
  );
endinterface

// File: rtl/freq_sweep_opt.sv
// Resonance-tracking frequency optimiser: sweeps F_MIN..F_MAX in F_STEP, settles, averages
// 2^AVG_LOG2 ADC samples per point and keeps the frequency with the highest mean.
// Ports: clk, nrst (sync, active-low), swipt_alive (low = sync reset), bus (freq_sweep_opt_if.slave).
module freq_sweep_opt #(
  parameter logic [19:0] F_MIN    = 20'd30000,
  parameter logic [19:0] F_MAX    = 20'd42000,
  parameter logic [19:0] F_STEP   = 20'd500,
  parameter logic [15:0] SETTLE   = 16'd1000,
  parameter int          AVG_LOG2 = 4
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           swipt_alive,
  freq_sweep_opt_if.slave bus
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [15:0]      SETTLE_LD = SETTLE - 16'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_COMPARE,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t            state_q;
  logic [15:0]       settle_cnt_q;
  logic [SMP_W-1:0]  smp_cnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic [19:0]       new_freq_q;
  logic [19:0]       best_freq_q;
  logic [11:0]       best_mag_q;
  logic              busy_q;
  logic              done_q;

  logic [11:0]       mean_d;
  logic [20:0]       sum_d;

  // Truncating mean; the extra sum bit keeps a step past 2^20-1 from wrapping below F_MAX.
  assign mean_d = acc_q[ACC_W-1:AVG_LOG2];
  assign sum_d  = {1'b0, new_freq_q} + {1'b0, F_STEP};

  always_ff @(posedge clk) begin
    if (!nrst || !swipt_alive) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      smp_cnt_q    <= '0;
      acc_q        <= '0;
      new_freq_q   <= F_MIN;
      best_freq_q  <= F_MIN;
      best_mag_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          new_freq_q <= F_MIN;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          if (bus.enable) begin
            acc_q        <= '0;
            smp_cnt_q    <= '0;
            best_mag_q   <= '0;
            best_freq_q  <= F_MIN;
            settle_cnt_q <= SETTLE_LD;
            busy_q       <= 1'b1;
            state_q      <= ST_SETTLE;
          end
        end

        ST_DONE: begin
          // Park the transmitter on the optimum; results stay until the next sweep starts.
          new_freq_q <= best_freq_q;
          if (!bus.enable) begin
            done_q     <= 1'b0;
            new_freq_q <= F_MIN;
            state_q    <= ST_IDLE;
          end
        end

        default: begin
          if (!bus.enable) begin
            // Abandoned sweep: partial results are meaningless, so discard them.
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            smp_cnt_q    <= '0;
            acc_q        <= '0;
            new_freq_q   <= F_MIN;
            best_freq_q  <= F_MIN;
            best_mag_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
          end else begin
            case (state_q)
              ST_SETTLE: begin
                // Counter loaded with SETTLE-1, so the state lasts exactly SETTLE cycles.
                if (settle_cnt_q == 16'd0) state_q <= ST_ACCUM;
                else                       settle_cnt_q <= settle_cnt_q - 16'd1;
              end

              ST_ACCUM: begin
                if (bus.adc_valid) begin
                  acc_q     <= acc_q + ACC_W'(bus.adc);
                  smp_cnt_q <= smp_cnt_q + 1'b1;
                  if (smp_cnt_q == LAST_SMP) state_q <= ST_COMPARE;
                end
              end

              ST_COMPARE: begin
                // Strict compare: on a tie the earlier (lower) frequency wins.
                if (mean_d > best_mag_q) begin
                  best_mag_q  <= mean_d;
                  best_freq_q <= new_freq_q;
                end
                acc_q     <= '0;
                smp_cnt_q <= '0;
                state_q   <= ST_NEXT;
              end

              ST_NEXT: begin
                if (sum_d > {1'b0, F_MAX}) begin
                  new_freq_q <= best_freq_q;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= ST_DONE;
                end else begin
                  new_freq_q   <= sum_d[19:0];
                  settle_cnt_q <= SETTLE_LD;
                  state_q      <= ST_SETTLE;
                end
              end

              default: state_q <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.new_freq  = new_freq_q;
  assign bus.best_freq = best_freq_q;
  assign bus.best_mag  = best_mag_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
